// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with a three-phase IDLE/ACCESS/RESP sequence
// Ports:
//   SYS_clk, SYS_reset (sync, active-low)
//   Rn_req_valid/ready, Rn_write, Rn_length, Rn_signed, Rn_address, Rn_write_data : request side, n in {0,1}
//   Rn_resp_valid, Rn_resp_error, Rn_read_data                                    : response side
//   MEM_* : single-port memory command bus, MEM_read_data is a combinational read path
module dmem_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        R0_req_valid,
  output logic        R0_req_ready,
  input  logic        R0_write,
  input  logic [1:0]  R0_length,
  input  logic        R0_signed,
  input  logic [31:0] R0_address,
  input  logic [31:0] R0_write_data,
  output logic        R0_resp_valid,
  output logic        R0_resp_error,
  output logic [31:0] R0_read_data,
  input  logic        R1_req_valid,
  output logic        R1_req_ready,
  input  logic        R1_write,
  input  logic [1:0]  R1_length,
  input  logic        R1_signed,
  input  logic [31:0] R1_address,
  input  logic [31:0] R1_write_data,
  output logic        R1_resp_valid,
  output logic        R1_resp_error,
  output logic [31:0] R1_read_data,
  output logic [1:0]  MEM_write_length,
  output logic [1:0]  MEM_read_length,
  output logic        MEM_read_signed,
  output logic [31:0] MEM_write_data,
  output logic [31:0] MEM_write_address,
  output logic [31:0] MEM_read_address,
  input  logic [31:0] MEM_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic        wr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
  state_t      state_q, state_d;
  cmd_t        cmd_q;
  logic        id_q, last_q, err_q;
  logic [31:0] rdata_q;
  logic        gnt0, gnt1, hs, mis, acc, resp;
  always_comb begin
    // last_q names the requester served last; a tie goes to the other one
    gnt0 = R0_req_valid & (!R1_req_valid | (PRIORITY_MODE != 0) | last_q);
    gnt1 = R1_req_valid & !gnt0;
    R0_req_ready = (state_q == IDLE) & SYS_reset & gnt0;
    R1_req_ready = (state_q == IDLE) & SYS_reset & gnt1;
    hs = R0_req_ready | R1_req_ready;
    state_d = state_q == IDLE ? (hs ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
    mis = (cmd_q.len == 2'b10 & cmd_q.addr[0]) | (cmd_q.len == 2'b11 & cmd_q.addr[1:0] != 2'b00);
    acc = state_q == ACCESS;
    // reset gates the write strobe combinationally so an interrupted store never commits
    MEM_write_length = acc & cmd_q.wr & !mis & SYS_reset ? cmd_q.len : 2'b00;
    MEM_read_length = acc & !cmd_q.wr & cmd_q.len != 2'b00 ? cmd_q.len : 2'b11;
    MEM_read_signed = acc & !cmd_q.wr & cmd_q.sgn;
    MEM_write_data = acc ? cmd_q.wdata : 32'd0;
    MEM_write_address = acc ? cmd_q.addr : 32'd0;
    MEM_read_address = acc ? cmd_q.addr : 32'd0;
    resp = (state_q == RESP) & SYS_reset;
    R0_resp_valid = resp & !id_q;
    R1_resp_valid = resp & id_q;
    R0_resp_error = R0_resp_valid & err_q;
    R1_resp_error = R1_resp_valid & err_q;
    R0_read_data = R0_resp_valid ? rdata_q : 32'd0;
    R1_read_data = R1_resp_valid ? rdata_q : 32'd0;
  end
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      id_q <= 1'b0;
      last_q <= 1'b1;
      err_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        id_q <= R1_req_ready;
        last_q <= R1_req_ready;
        cmd_q <= R1_req_ready ? {R1_write, R1_length, R1_signed, R1_address, R1_write_data}
                              : {R0_write, R0_length, R0_signed, R0_address, R0_write_data};
      end
      if (acc) begin
        err_q <= mis;
        rdata_q <= !cmd_q.wr & !mis ? MEM_read_data : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, arbitration/reset sequences and randomized checks against a transaction model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        vld [2];
  logic        wr [2];
  logic [1:0]  ln [2];
  logic        sg [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        rdy [2];
  logic        rv [2];
  logic        re [2];
  logic [31:0] rd [2];
  logic        frdy [2];
  logic        frv [2];
  logic        fre [2];
  logic [31:0] frd [2];
  logic [1:0]  mem_wl, mem_rl, f_wl, f_rl;
  logic        mem_rs, f_rs;
  logic [31:0] mem_wd, mem_wa, mem_ra, mem_rdata, f_wd, f_wa, f_ra;
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] mem_b;
  int vectors = 0;
  int miscompares = 0;
  dmem_arbiter #(.PRIORITY_MODE(0)) dut (
    .SYS_clk(clk), .SYS_reset(rst_n),
    .R0_req_valid(vld[0]), .R0_req_ready(rdy[0]), .R0_write(wr[0]), .R0_length(ln[0]),
    .R0_signed(sg[0]), .R0_address(ad[0]), .R0_write_data(wd[0]),
    .R0_resp_valid(rv[0]), .R0_resp_error(re[0]), .R0_read_data(rd[0]),
    .R1_req_valid(vld[1]), .R1_req_ready(rdy[1]), .R1_write(wr[1]), .R1_length(ln[1]),
    .R1_signed(sg[1]), .R1_address(ad[1]), .R1_write_data(wd[1]),
    .R1_resp_valid(rv[1]), .R1_resp_error(re[1]), .R1_read_data(rd[1]),
    .MEM_write_length(mem_wl), .MEM_read_length(mem_rl), .MEM_read_signed(mem_rs),
    .MEM_write_data(mem_wd), .MEM_write_address(mem_wa), .MEM_read_address(mem_ra),
    .MEM_read_data(mem_rdata)
  );
  dmem_arbiter #(.PRIORITY_MODE(1)) dut_fixed (
    .SYS_clk(clk), .SYS_reset(rst_n),
    .R0_req_valid(vld[0]), .R0_req_ready(frdy[0]), .R0_write(wr[0]), .R0_length(ln[0]),
    .R0_signed(sg[0]), .R0_address(ad[0]), .R0_write_data(wd[0]),
    .R0_resp_valid(frv[0]), .R0_resp_error(fre[0]), .R0_read_data(frd[0]),
    .R1_req_valid(vld[1]), .R1_req_ready(frdy[1]), .R1_write(wr[1]), .R1_length(ln[1]),
    .R1_signed(sg[1]), .R1_address(ad[1]), .R1_write_data(wd[1]),
    .R1_resp_valid(frv[1]), .R1_resp_error(fre[1]), .R1_read_data(frd[1]),
    .MEM_write_length(f_wl), .MEM_read_length(f_rl), .MEM_read_signed(f_rs),
    .MEM_write_data(f_wd), .MEM_write_address(f_wa), .MEM_read_address(f_ra),
    .MEM_read_data(32'd0)
  );
  // memory behind the round-robin instance: combinational read, write on the clock edge
  always_comb begin
    mem_b = {mem[8'(mem_ra[7:0] + 8'd3)], mem[8'(mem_ra[7:0] + 8'd2)],
             mem[8'(mem_ra[7:0] + 8'd1)], mem[mem_ra[7:0]]};
    mem_rdata = mem_rl == 2'b01 ? {{24{mem_rs & mem_b[7]}}, mem_b[7:0]} :
                mem_rl == 2'b10 ? {{16{mem_rs & mem_b[15]}}, mem_b[15:0]} : mem_b;
  end
  always @(posedge clk) begin
    if (mem_wl != 2'b00) mem[mem_wa[7:0]] <= mem_wd[7:0];
    if (mem_wl[1]) mem[8'(mem_wa[7:0] + 8'd1)] <= mem_wd[15:8];
    if (mem_wl == 2'b11) begin
      mem[8'(mem_wa[7:0] + 8'd2)] <= mem_wd[23:16];
      mem[8'(mem_wa[7:0] + 8'd3)] <= mem_wd[31:24];
    end
  end
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] l);
    return l == 2'b01 ? 1 : l == 2'b10 ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] l, input bit s);
    int n;
    logic [31:0] v;
    n = nbytes(l);
    v = 0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[8'(a + 32'(i))]) << (8 * i);
    if (s && n < 4 && v[8 * n - 1]) v |= 32'hFFFFFFFF << (8 * n);
    return v;
  endfunction
  task automatic ref_store(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    for (int i = 0; i < nbytes(l); i++) ref_mem[8'(a + 32'(i))] = d[8 * i +: 8];
  endtask
  task automatic idle_inputs();
    for (int r = 0; r < 2; r++) begin
      vld[r] = 0; wr[r] = 0; ln[r] = 2'b11; sg[r] = 0; ad[r] = 0; wd[r] = 0;
    end
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  typedef struct {
    int          r;
    bit          w;
    logic [1:0]  l;
    bit          s;
    logic [31:0] a;
    logic [31:0] d;
    bit          e;
    logic [31:0] q;
  } txn_t;
  txn_t tbl [15];
  task automatic do_txn(input txn_t x, input string nm);
    int n;
    @(negedge clk);
    idle_inputs();
    vld[x.r] = 1; wr[x.r] = x.w; ln[x.r] = x.l; sg[x.r] = x.s; ad[x.r] = x.a; wd[x.r] = x.d;
    #1;
    n = 0;
    while (!rdy[x.r] && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 10) begin
      chk({nm, "_grant_timeout"}, 96'(rdy[x.r]), 96'd1);
      idle_inputs();
      return;
    end
    @(negedge clk);
    vld[x.r] = 0;
    #1;
    chk({nm, "_access_novalid"}, 96'({rv[0], rv[1]}), 96'd0);
    @(negedge clk);
    #1;
    chk({nm, "_resp"}, 96'({rv[x.r], rv[1 - x.r], re[x.r], rd[x.r]}), 96'({1'b1, 1'b0, x.e, x.q}));
    @(negedge clk);
    #1;
    chk({nm, "_pulse_end"}, 96'({rv[0], rv[1]}), 96'd0);
  endtask
  int q0 [$];
  int q1 [$];
  logic [31:0] old30;
  int seen, got;
  int last_hs, exp_t;
  bit last_srv, e0, e1, erv0, erv1;
  bit p_id, p_w, p_s, x_id, x_e, pmis;
  logic [1:0] p_l;
  logic [31:0] p_a, p_d, x_d;
  logic [69:0] act, exp;
  initial begin
    tbl[0]  = '{0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{0, 0, 2'b11, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF};
    tbl[2]  = '{1, 1, 2'b01, 0, 32'h13, 32'h80, 0, 32'h0};
    tbl[3]  = '{1, 0, 2'b01, 1, 32'h13, 32'h0, 0, 32'hFFFFFF80};
    tbl[4]  = '{1, 0, 2'b01, 0, 32'h13, 32'h0, 0, 32'h00000080};
    tbl[5]  = '{0, 1, 2'b11, 0, 32'h20, 32'h11223344, 0, 32'h0};
    tbl[6]  = '{0, 1, 2'b10, 0, 32'h21, 32'h0000AAAA, 1, 32'h0};
    tbl[7]  = '{0, 0, 2'b11, 0, 32'h20, 32'h0, 0, 32'h11223344};
    tbl[8]  = '{1, 1, 2'b00, 0, 32'h20, 32'hFFFFFFFF, 0, 32'h0};
    tbl[9]  = '{1, 0, 2'b11, 0, 32'h20, 32'h0, 0, 32'h11223344};
    tbl[10] = '{0, 0, 2'b11, 0, 32'h22, 32'h0, 1, 32'h0};
    tbl[11] = '{1, 0, 2'b10, 1, 32'h12, 32'h0, 0, 32'hFFFF80AD};
    tbl[12] = '{0, 0, 2'b00, 1, 32'h10, 32'h0, 0, 32'h80ADBEEF};
    tbl[13] = '{0, 1, 2'b10, 0, 32'h22, 32'h1234, 0, 32'h0};
    tbl[14] = '{1, 0, 2'b11, 0, 32'h20, 32'h0, 0, 32'h12343344};
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("reset_outputs", 96'({rdy[0], rdy[1], rv[0], rv[1], re[0], re[1], rd[0], rd[1]}), 96'd0);
    vld[0] = 1; vld[1] = 1;
    #1;
    chk("reset_ready_low", 96'({rdy[0], rdy[1], frdy[0], frdy[1]}), 96'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    foreach (tbl[i]) do_txn(tbl[i], $sformatf("tbl%0d", i));
    // both requesters valid continuously: round-robin alternates, fixed priority starves R1
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      vld[r] = 1; ad[r] = 32'h4 * 32'(r);
    end
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rdy[0]) q0.push_back(0);
      if (rdy[1]) q0.push_back(1);
      if (frdy[0]) q1.push_back(0);
      if (frdy[1]) q1.push_back(1);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), 96'(i < q0.size() ? q0[i] : 9), 96'(i % 2));
      chk($sformatf("fixed_grant%0d", i), 96'(i < q1.size() ? q1[i] : 9), 96'd0);
    end
    vld[0] = 0;
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      if (frdy[1]) got = 1;
      @(negedge clk);
    end
    chk("fixed_r1_after_r0_drops", 96'(got), 96'd1);
    // reset during a store ACCESS drops the store and its response
    reset_dut();
    old30 = {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]};
    vld[0] = 1; wr[0] = 1; ln[0] = 2'b11; ad[0] = 32'h30; wd[0] = 32'hCAFEF00D;
    #1;
    chk("rst_store_ready", 96'(rdy[0]), 96'd1);
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst_access_gated", 96'({mem_wl, rdy[0], rdy[1], rv[0], rv[1]}), 96'd0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rv[0] || rv[1]) seen = 1;
      @(negedge clk);
    end
    chk("rst_no_resp", 96'(seen), 96'd0);
    vld[0] = 1; vld[1] = 1;
    #1;
    chk("rst_tie_r0", 96'({rdy[0], rdy[1]}), 96'b10);
    chk("rst_mem_unchanged", 96'({mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}), 96'(old30));
    do_txn('{0, 0, 2'b11, 0, 32'h30, 32'h0, 0, old30}, "rst_readback");
    // randomized traffic against a transaction-level model
    reset_dut();
    foreach (ref_mem[i]) ref_mem[i] = mem[i];
    last_hs = -100; last_srv = 1; exp_t = -1;
    x_id = 0; x_e = 0; x_d = 0;
    p_id = 0; p_w = 0; p_l = 0; p_s = 0; p_a = 0; p_d = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      rst_n = $urandom_range(0, 59) != 0;
      for (int r = 0; r < 2; r++) begin
        vld[r] = $urandom_range(0, 2) != 0;
        wr[r] = 1'($urandom_range(0, 1));
        ln[r] = 2'($urandom_range(0, 3));
        sg[r] = 1'($urandom_range(0, 1));
        ad[r] = 32'($urandom_range(0, 60));
        wd[r] = $urandom;
      end
      #1;
      e0 = rst_n && t - last_hs >= 3 && vld[0] && (!vld[1] || last_srv);
      e1 = rst_n && t - last_hs >= 3 && vld[1] && !e0;
      erv0 = rst_n && exp_t == t && !x_id;
      erv1 = rst_n && exp_t == t && x_id;
      if (rst_n && t == last_hs + 1) begin
        pmis = (p_l == 2'b10 && p_a[0]) || (p_l == 2'b11 && p_a[1:0] != 2'b00);
        x_id = p_id;
        x_e = pmis;
        x_d = p_w || pmis ? 32'd0 : ref_load(p_a, p_l, p_s);
        if (p_w && !pmis && p_l != 2'b00) ref_store(p_a, p_l, p_d);
        exp_t = t + 1;
      end
      exp = {e0, e1, erv0, erv1, erv0 ? {x_e, x_d} : 33'd0, erv1 ? {x_e, x_d} : 33'd0};
      act = {rdy[0], rdy[1], rv[0], rv[1], erv0 ? {re[0], rd[0]} : 33'd0, erv1 ? {re[1], rd[1]} : 33'd0};
      chk($sformatf("rand_cycle%0d", t), 96'(act), 96'(exp));
      if (!rst_n) begin
        last_hs = -100; last_srv = 1; exp_t = -1;
      end else if (e0 || e1) begin
        last_hs = t; last_srv = e1; p_id = e1;
        p_w = wr[32'(e1)]; p_l = ln[32'(e1)]; p_s = sg[32'(e1)]; p_a = ad[32'(e1)]; p_d = wd[32'(e1)];
      end
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    repeat (4) @(negedge clk);
    seen = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) seen++;
    chk("rand_mem_image", 96'(seen), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide parameter PRIORITY_MODE, default 0; 0 selects round-robin arbitration, 1 selects fixed priority with R0 always winning.
REQ-002 SHALL provide ports SYS_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL provide SYS_reset  in  1  synchronous, active-low reset.
REQ-004 SHALL provide, for each requester n in {0,1}, Rn_req_valid  in  1  request present.
REQ-005 SHALL provide Rn_req_ready  out  1  request accepted this cycle when high together with Rn_req_valid.
REQ-006 SHALL provide Rn_write  in  1  1 = store, 0 = load.
REQ-007 SHALL provide Rn_length  in  2  01 byte, 10 halfword, 11 word, 00 none.
REQ-008 SHALL provide Rn_signed  in  1  sign-extend load result.
REQ-009 SHALL provide Rn_address  in  32  byte address, plus Rn_write_data  in  32  store data in bits [7:0]/[15:0]/[31:0].
REQ-010 SHALL provide Rn_resp_valid  out  1  one-cycle completion pulse, plus Rn_resp_error  out  1  misalignment flag, qualified by Rn_resp_valid.
REQ-011 SHALL provide Rn_read_data  out  32  load result, qualified by Rn_resp_valid.
REQ-012 SHALL provide the memory-side ports MEM_write_length  out  2, MEM_read_length  out  2, MEM_read_signed  out  1, MEM_write_data  out  32, MEM_write_address  out  32, MEM_read_address  out  32, and MEM_read_data  in  32 (combinational read path).

Function
REQ-013 SHALL implement a three-state FSM: IDLE -> ACCESS -> RESP -> IDLE, one cycle each in ACCESS and RESP.
REQ-014 SHALL assert Rn_req_ready only in IDLE and only for the requester selected by arbitration in that cycle; at most one ready is high per cycle.
REQ-015 SHALL, on a handshake (valid & ready), latch write, length, signed, address, write_data and the requester ID, then enter ACCESS.
REQ-016 SHALL arbitrate with a single valid requester by granting it; with both valid in round-robin mode, it SHALL grant the requester not served last; in fixed mode, it SHALL grant R0.
REQ-017 SHALL update the last-served register only on a handshake.
REQ-018 SHALL, in ACCESS, drive MEM_read_address and MEM_write_address with the latched address and MEM_write_data with the latched data.
REQ-019 SHALL, in ACCESS for a store, drive MEM_write_length with the latched length, so the memory commits at the ACCESS->RESP edge.
REQ-020 SHALL, in ACCESS for a load, drive MEM_read_length and MEM_read_signed from the latched fields, map length 00 to 11, and register MEM_read_data at the ACCESS->RESP edge.
REQ-021 SHALL, outside ACCESS, drive MEM_write_length=00, MEM_read_length=11, MEM_read_signed=0 and all address/data buses to 0.
REQ-022 SHALL treat a halfword with address[0]=1, or a word with address[1:0]!=00, as misaligned.
REQ-023 SHALL not write memory on a misaligned request; it SHALL return read_data=0 and resp_error=1.
REQ-024 SHALL treat a store with length 00 as a no-op: no memory write, response pulse with error=0.
REQ-025 SHALL, in RESP, assert resp_valid for exactly one cycle to the latched requester only; read_data SHALL hold the registered value (0 for stores), and the other requester's outputs SHALL stay 0.
REQ-026 SHALL give a response latency of exactly 2 cycles after the handshake edge and a throughput of one transaction per 3 cycles.
REQ-027 SHALL not require a requester to hold valid after its handshake; a requester deasserting valid before a handshake SHALL not be granted.

Reset
REQ-028 SHALL, when SYS_reset=0 at a rising edge, enter IDLE, clear the latched command and response registers, and set last-served to R1, so R0 wins the first round-robin tie.
REQ-029 SHALL, while SYS_reset=0, drive all Rn_req_ready, Rn_resp_valid, Rn_resp_error and Rn_read_data outputs to 0.
REQ-030 SHALL combinationally gate MEM_write_length to 00 whenever SYS_reset=0, so reset asserted during a store ACCESS commits no write; the in-flight transaction SHALL be dropped without a response.

Verification
REQ-031 SHALL cover: R0 store word 0xDEADBEEF @0x10, then R0 load word @0x10 -> resp_valid 2 cycles after each handshake, read_data=0xDEADBEEF.
REQ-032 SHALL cover: R1 load byte signed @0x13 holding 0x80 -> read_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 SHALL cover: both valid continuously with PRIORITY_MODE=0 -> grants R0,R1,R0,R1; with PRIORITY_MODE=1 -> R0 every time, and R1 only after R0 drops valid.
REQ-034 SHALL cover: R0 store halfword @0x21 -> resp_error=1, read_data=0, memory @0x20-0x23 unchanged on readback.
REQ-035 SHALL cover: SYS_reset=0 during a store ACCESS @0x30 -> MEM_write_length=00 that cycle, no resp_valid, FSM in IDLE on release, next tie granted to R0.
